// File: rtl/calc3_if.sv
// Request/response bus of the three-operation calculator core.
interface calc3_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 2
);
    logic [NUM_PORTS*4-1:0]      req_cmd_in;
    logic [NUM_PORTS*DATA_W-1:0] req_data_in;
    logic [NUM_PORTS*TAG_W-1:0]  req_tag_in;
    logic [NUM_PORTS*2-1:0]      out_resp;
    logic [NUM_PORTS*DATA_W-1:0] out_data;
    logic [NUM_PORTS*TAG_W-1:0]  out_tag;
    logic [NUM_PORTS-1:0]        port_full;
    logic [NUM_PORTS-1:0]        drop_err;

    modport master (
        output req_cmd_in, req_data_in, req_tag_in,
        input  out_resp, out_data, out_tag, port_full, drop_err
    );

    modport slave (
        input  req_cmd_in, req_data_in, req_tag_in,
        output out_resp, out_data, out_tag, port_full, drop_err
    );
endinterface

// File: rtl/calc3_core.sv
// Multi-port calculator: per-port two-cycle capture into a request queue,
// round-robin dispatch to a shared ALU pipeline, response on the source port.
module calc3_core #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ALU_LAT    = 1
) (
    input  logic     c_clk,
    input  logic     reset,
    calc3_if.slave   bus
);
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned SH_W   = $clog2(DATA_W);
    localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned PTR1_W = PTR_W + 1;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;
    localparam logic [1:0]       RESP_OK  = 2'b01;
    localparam logic [1:0]       RESP_ERR = 2'b10;

    typedef enum logic {ST_IDLE, ST_OP2} cap_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [PTR_W-1:0]  port;
        logic [1:0]        resp;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rsp_t;

    cap_state_e        state_q [NUM_PORTS];
    cap_state_e        state_d [NUM_PORTS];
    logic [CMD_W-1:0]  cmd_q   [NUM_PORTS];
    logic [CMD_W-1:0]  cmd_d   [NUM_PORTS];
    logic [TAG_W-1:0]  tag_q   [NUM_PORTS];
    logic [TAG_W-1:0]  tag_d   [NUM_PORTS];
    logic [DATA_W-1:0] op1_q   [NUM_PORTS];
    logic [DATA_W-1:0] op1_d   [NUM_PORTS];
    logic [CNT_W-1:0]  cnt_q   [NUM_PORTS];
    logic [CNT_W-1:0]  cnt_d   [NUM_PORTS];
    logic [AW-1:0]     wr_q    [NUM_PORTS];
    logic [AW-1:0]     wr_d    [NUM_PORTS];
    logic [AW-1:0]     rd_q    [NUM_PORTS];
    logic [AW-1:0]     rd_d    [NUM_PORTS];
    req_t              push_data_c [NUM_PORTS];
    req_t              mem_q [NUM_PORTS][FIFO_DEPTH];

    logic [NUM_PORTS-1:0] drop_q, drop_d;
    logic [NUM_PORTS-1:0] push_c, pop_c, ne_c, rot_c, full_c;
    logic [PTR_W-1:0]     rr_q, rr_d, grant_c;
    logic [PTR1_W-1:0]    sel_c, nxt_c;
    logic                 grant_vld_c;
    logic [DATA_W:0]      sum_c;
    req_t                 head_c;
    rsp_t                 stage_d, pre_c;

    logic [NUM_PORTS*2-1:0]      out_resp_q, out_resp_d;
    logic [NUM_PORTS*DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_PORTS*TAG_W-1:0]  out_tag_q,  out_tag_d;

    // Capture FSM: command cycle latches cmd/tag/op1, next cycle supplies op2 and pushes.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        tag_d   = tag_q;
        op1_d   = op1_q;
        drop_d  = drop_q;
        push_c  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            push_data_c[i] = '{cmd: cmd_q[i], tag: tag_q[i], op1: op1_q[i],
                               op2: bus.req_data_in[DATA_W*i +: DATA_W]};
            if (state_q[i] == ST_IDLE) begin
                if (bus.req_cmd_in[CMD_W*i +: CMD_W] != '0) begin
                    if (cnt_q[i] == CNT_W'(FIFO_DEPTH)) begin
                        drop_d[i] = 1'b1;
                    end else begin
                        cmd_d[i]   = bus.req_cmd_in[CMD_W*i +: CMD_W];
                        tag_d[i]   = bus.req_tag_in[TAG_W*i +: TAG_W];
                        op1_d[i]   = bus.req_data_in[DATA_W*i +: DATA_W];
                        state_d[i] = ST_OP2;
                    end
                end
            end else begin
                push_c[i]  = 1'b1;
                state_d[i] = ST_IDLE;
            end
        end
    end

    // Round-robin pick: rotate the non-empty mask so rr_q sits at bit 0.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_c     = '0;
        sel_c       = '0;
        pop_c       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ne_c[i] = (cnt_q[i] != '0);
        end
        rot_c = NUM_PORTS'({ne_c, ne_c} >> rr_q);
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!grant_vld_c && rot_c[j]) begin
                grant_vld_c = 1'b1;
                sel_c = PTR1_W'(rr_q) + PTR1_W'(j);
                if (sel_c >= PTR1_W'(NUM_PORTS)) begin
                    sel_c = sel_c - PTR1_W'(NUM_PORTS);
                end
                grant_c = PTR_W'(sel_c);
            end
        end
        nxt_c = PTR1_W'(grant_c) + PTR1_W'(1);
        rr_d  = rr_q;
        if (grant_vld_c) begin
            pop_c[grant_c] = 1'b1;
            rr_d = (nxt_c >= PTR1_W'(NUM_PORTS)) ? '0 : PTR_W'(nxt_c);
        end
    end

    // ALU on the granted queue head; overflow/underflow/unknown op report error with zero data.
    always_comb begin
        head_c  = mem_q[grant_c][rd_q[grant_c]];
        sum_c   = {1'b0, head_c.op1} + {1'b0, head_c.op2};
        stage_d = '{valid: grant_vld_c, port: grant_c, resp: RESP_ERR,
                    tag: head_c.tag, data: '0};
        case (head_c.cmd)
            CMD_ADD: if (!sum_c[DATA_W]) begin
                stage_d.resp = RESP_OK;
                stage_d.data = sum_c[DATA_W-1:0];
            end
            CMD_SUB: if (head_c.op1 >= head_c.op2) begin
                stage_d.resp = RESP_OK;
                stage_d.data = head_c.op1 - head_c.op2;
            end
            CMD_SHL: begin
                stage_d.resp = RESP_OK;
                stage_d.data = head_c.op1 << head_c.op2[SH_W-1:0];
            end
            CMD_SHR: begin
                stage_d.resp = RESP_OK;
                stage_d.data = head_c.op1 >> head_c.op2[SH_W-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            full_c[i] = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
            if (push_c[i]) wr_d[i] = wr_q[i] + AW'(1);
            if (pop_c[i])  rd_d[i] = rd_q[i] + AW'(1);
            if (push_c[i] && !pop_c[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!push_c[i] && pop_c[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    if (ALU_LAT > 1) begin : g_pipe
        rsp_t pipe_q [ALU_LAT-1];
        always_ff @(posedge c_clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < ALU_LAT-1; k++) pipe_q[k] <= '0;
            end else begin
                pipe_q[0] <= stage_d;
                for (int k = 1; k < ALU_LAT-1; k++) pipe_q[k] <= pipe_q[k-1];
            end
        end
        assign pre_c = pipe_q[ALU_LAT-2];
    end else begin : g_direct
        assign pre_c = stage_d;
    end

    // Route the final pipeline stage onto its source port; every other lane reads zero.
    always_comb begin
        out_resp_d = '0;
        out_data_d = '0;
        out_tag_d  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pre_c.valid && pre_c.port == PTR_W'(i)) begin
                out_resp_d[2*i +: 2]          = pre_c.resp;
                out_data_d[DATA_W*i +: DATA_W] = pre_c.data;
                out_tag_d[TAG_W*i +: TAG_W]    = pre_c.tag;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push_c[i]) mem_q[i][wr_q[i]] <= push_data_c[i];
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ST_IDLE;
                cmd_q[i]   <= '0;
                tag_q[i]   <= '0;
                op1_q[i]   <= '0;
                cnt_q[i]   <= '0;
                wr_q[i]    <= '0;
                rd_q[i]    <= '0;
            end
            drop_q     <= '0;
            rr_q       <= '0;
            out_resp_q <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            tag_q      <= tag_d;
            op1_q      <= op1_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            drop_q     <= drop_d;
            rr_q       <= rr_d;
            out_resp_q <= out_resp_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign bus.out_resp  = out_resp_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.port_full = full_c;
    assign bus.drop_err  = drop_q;
endmodule

// File: tb/tb_calc3_core.sv
// Bench for calc3_core: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed responses.
module tb_calc3_core;
    localparam int unsigned NP    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned TW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 1;

    logic c_clk = 1'b0;
    logic reset;
    always #5 c_clk = ~c_clk;

    calc3_if #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

    calc3_core #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW),
                 .FIFO_DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
    } req_s;

    typedef struct {
        int          due;
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } exp_s;

    req_s          mq [NP][$];
    req_s          pend [NP];
    bit            m_op2 [NP];
    logic [NP-1:0] m_drop;
    int            m_rr;
    int            cyc;
    exp_s          expq [$];

    int            n_checks;
    int            n_errors;
    int            accepted;
    int            resp_seen;
    logic [NP-1:0] saw_full;
    logic [3:0]    cmds [5] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, want, $time);
        end
    endtask

    // Arithmetic meaning of each command, straight from the operation definitions.
    function automatic void alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d);
        logic [63:0] s;
        r = 2'b10;
        d = 32'd0;
        case (c)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s <= 64'hFFFF_FFFF) begin r = 2'b01; d = s[31:0]; end
            end
            4'd2: if (a >= b) begin r = 2'b01; d = a - b; end
            4'd5: begin r = 2'b01; d = a << b[4:0]; end
            4'd6: begin r = 2'b01; d = a >> b[4:0]; end
            default: ;
        endcase
    endfunction

    function automatic bit model_idle();
        for (int i = 0; i < NP; i++) begin
            if (mq[i].size() != 0 || m_op2[i]) return 1'b0;
        end
        return expq.size() == 0;
    endfunction

    // Reference model, advanced once per cycle with the inputs of the cycle just ending.
    always @(posedge c_clk or negedge reset) begin : model
        int          sz [NP];
        int          idx;
        bit          got;
        req_s        rq;
        logic [1:0]  r;
        logic [31:0] d;
        logic [3:0]  c;
        if (!reset) begin
            for (int i = 0; i < NP; i++) begin
                mq[i].delete();
                m_op2[i] = 1'b0;
            end
            m_drop = '0;
            m_rr   = 0;
            expq.delete();
        end else begin
            for (int i = 0; i < NP; i++) sz[i] = mq[i].size();
            got = 1'b0;
            for (int k = 0; k < NP; k++) begin
                idx = (m_rr + k) % NP;
                if (!got && sz[idx] > 0) begin
                    got = 1'b1;
                    rq  = mq[idx].pop_front();
                    alu(rq.cmd, rq.op1, rq.op2, r, d);
                    expq.push_back('{due: cyc + LAT, port: idx, resp: r, data: d, tag: rq.tag});
                    m_rr = (idx + 1) % NP;
                end
            end
            for (int i = 0; i < NP; i++) begin
                c = bus.req_cmd_in[4*i +: 4];
                if (m_op2[i]) begin
                    rq = pend[i];
                    rq.op2 = bus.req_data_in[32*i +: 32];
                    mq[i].push_back(rq);
                    m_op2[i] = 1'b0;
                    accepted++;
                end else if (c != 4'd0) begin
                    if (sz[i] == DEPTH) begin
                        m_drop[i] = 1'b1;
                    end else begin
                        pend[i] = '{cmd: c, tag: bus.req_tag_in[2*i +: 2],
                                    op1: bus.req_data_in[32*i +: 32], op2: 32'd0};
                        m_op2[i] = 1'b1;
                    end
                end
            end
            while (expq.size() > 0 && expq[0].due <= cyc) void'(expq.pop_front());
            cyc++;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge c_clk) begin : compare
        logic [2*NP-1:0]  er;
        logic [DW*NP-1:0] ed;
        logic [TW*NP-1:0] et;
        logic [NP-1:0]    ef;
        er = '0;
        ed = '0;
        et = '0;
        for (int k = 0; k < expq.size(); k++) begin
            if (expq[k].due == cyc) begin
                er[2*expq[k].port +: 2]  = expq[k].resp;
                ed[32*expq[k].port +: 32] = expq[k].data;
                et[2*expq[k].port +: 2]  = expq[k].tag;
            end
        end
        for (int i = 0; i < NP; i++) ef[i] = (mq[i].size() == DEPTH);
        chk("cyc_resp", 128'(bus.out_resp), 128'(er));
        chk("cyc_data", 128'(bus.out_data), 128'(ed));
        chk("cyc_tag", 128'(bus.out_tag), 128'(et));
        chk("cyc_full", 128'(bus.port_full), 128'(ef));
        chk("cyc_drop", 128'(bus.drop_err), 128'(m_drop));
        for (int i = 0; i < NP; i++) begin
            if (bus.out_resp[2*i +: 2] != 2'b00) resp_seen++;
        end
        saw_full = saw_full | bus.port_full;
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
        bus.req_cmd_in[4*p +: 4]   = c;
        bus.req_data_in[32*p +: 32] = d;
        bus.req_tag_in[2*p +: 2]   = t;
    endtask

    task automatic clear_all();
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
        bus.req_tag_in  = '0;
    endtask

    task automatic do_reset();
        clear_all();
        reset = 1'b0;
        repeat (2) @(posedge c_clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_resp"}, 128'(bus.out_resp), 128'd0);
        chk({nm, "_data"}, 128'(bus.out_data), 128'd0);
        chk({nm, "_tag"}, 128'(bus.out_tag), 128'd0);
        chk({nm, "_full"}, 128'(bus.port_full), 128'd0);
        chk({nm, "_drop"}, 128'(bus.drop_err), 128'd0);
    endtask

    // One isolated request: nothing in cycle 2, the literal response in cycle 3.
    task automatic run_one(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] tg, input logic [1:0] er, input logic [31:0] ed,
                           input string nm);
        drive(p, c, a, tg);
        tick();
        drive(p, 4'd0, b, 2'd0);
        tick();
        drive(p, 4'd0, 32'd0, 2'd0);
        @(negedge c_clk);
        chk({nm, "_early"}, 128'(bus.out_resp), 128'd0);
        tick();
        @(negedge c_clk);
        chk({nm, "_resp"}, 128'(bus.out_resp[2*p +: 2]), 128'(er));
        chk({nm, "_data"}, 128'(bus.out_data[32*p +: 32]), 128'(ed));
        chk({nm, "_tag"}, 128'(bus.out_tag[2*p +: 2]), 128'(tg));
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        n_checks  = 0;
        n_errors  = 0;
        accepted  = 0;
        resp_seen = 0;
        saw_full  = '0;
        cyc       = 0;
        clear_all();
        reset = 1'b0;
        repeat (3) @(posedge c_clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        run_one(0, 4'd1, 32'h30, 32'h20, 2'd1, 2'b01, 32'h0000_0050, "add_basic");
        run_one(1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 2'b10, 32'd0, "add_ovf");
        run_one(1, 4'd2, 32'h5, 32'h6, 2'd3, 2'b10, 32'd0, "sub_neg");
        run_one(1, 4'd5, 32'h1, 32'h21, 2'd0, 2'b01, 32'h2, "shl_mask");
        run_one(1, 4'd3, 32'h7, 32'h7, 2'd1, 2'b10, 32'd0, "bad_cmd");
        run_one(1, 4'd6, 32'h80, 32'h4, 2'd2, 2'b01, 32'h8, "shr");
        run_one(1, 4'd2, 32'h6, 32'h5, 2'd3, 2'b01, 32'h1, "sub_ok");

        // All four ports at once: served 0,1,2,3 in cycles 3..6.
        do_reset();
        for (int i = 0; i < NP; i++) drive(i, 4'd1, 32'(16*i + 1), 2'(i));
        tick();
        for (int i = 0; i < NP; i++) drive(i, 4'd0, 32'd2, 2'd0);
        tick();
        clear_all();
        tick();
        for (int c = 0; c < NP; c++) begin
            @(negedge c_clk);
            chk("rr_resp", 128'(bus.out_resp), 128'(8'(2'b01 << (2*c))));
            chk("rr_data", 128'(bus.out_data[32*c +: 32]), 128'(16*c + 3));
            chk("rr_tag", 128'(bus.out_tag[2*c +: 2]), 128'(c));
            tick();
        end

        // Saturating load: back-to-back commands on every port for 20 cycles.
        do_reset();
        accepted  = 0;
        resp_seen = 0;
        saw_full  = '0;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NP; i++) begin
                drive(i, cmds[(k + i) % 5], 32'(32'h9E37_79B9 * (k*4 + i + 1)), 2'((k + i) % 4));
            end
            tick();
        end
        clear_all();
        for (int w = 0; w < 200 && !model_idle(); w++) tick();
        chk("drain_done", 128'(model_idle()), 128'd1);
        repeat (4) tick();
        chk("resp_count", 128'(resp_seen), 128'(accepted));
        chk("full_seen", 128'(saw_full != '0), 128'd1);
        chk("drop_set", 128'(bus.drop_err != '0), 128'd1);

        // Asynchronous reset clears the sticky drop flags mid-cycle.
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst1");
        repeat (2) tick();
        reset = 1'b1;

        // Reset with three requests queued and one in the ALU.
        for (int i = 0; i < NP; i++) drive(i, 4'd1, 32'(256*(i + 1)), 2'(i));
        tick();
        for (int i = 0; i < NP; i++) drive(i, 4'd0, 32'd1, 2'd0);
        tick();
        clear_all();
        drive(0, 4'd1, 32'h7, 2'd0);
        tick();
        drive(0, 4'd0, 32'h1, 2'd0);
        @(negedge c_clk);
        chk("pre_rst_resp", 128'(bus.out_resp), 128'h01);
        chk("pre_rst_data", 128'(bus.out_data[31:0]), 128'h101);
        #2;
        reset = 1'b0;
        clear_all();
        #1;
        check_all_zero("async_rst2");
        repeat (2) tick();
        reset = 1'b1;
        repeat (8) tick();
        run_one(2, 4'd1, 32'h3, 32'h4, 2'd3, 2'b01, 32'h7, "post_rst_add");
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
